piso_serial_tx: RTL

// - Parallel-in/serial-out transmitter: the source end of the single-bit din/dout serial link.
// - Accepts a WIDTH-bit word over a valid/ready handshake.
// - Drives the word one bit per clk onto a registered serial line that a downstream

---
 rtl/piso_serial_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in/serial-out transmitter, source end of a din/dout serial link.
//
// A WIDTH-bit word is accepted over a valid/ready handshake and driven one bit per clock onto
// a registered serial line. Frames are marked with dout_valid/dout_last. A new word may be
// accepted on the final bit of the current frame, giving gapless back-to-back frames.
//
// Optional feature (compile-time macro PISO_SERIAL_TX_PARITY_EN):
//   defined   - an even-parity bit (XOR of the word) follows the data bits, NBITS = WIDTH+1
//   undefined - data bits only, NBITS = WIDTH
//
// Parameters:
//   WIDTH      data bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 first (shift left); 0: bit 0 first (shift right)
//
// Ports:
//   clk         in   clock, all state updates on posedge
//   rst         in   asynchronous active-high reset
//   load_valid  in   upstream word available
//   load_ready  out  word can be accepted this cycle (from registered state only)
//   load_data   in   word, sampled on the accept edge only
//   dout        out  serial data bit (registered)
//   dout_valid  out  dout carries a frame bit
//   dout_last   out  dout is the final bit of the frame
//   busy        out  frame in progress (same as dout_valid)

module piso_serial_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

`ifdef PISO_SERIAL_TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(NBITS + 1);

  localparam logic [CW-1:0] LastCnt     = CW'(NBITS - 1);
  localparam logic [CW-1:0] DataLastCnt = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_dout, w_dout_nxt;

  logic             w_accept;
  logic             w_last;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_first_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_rest;
  logic             w_par_slot;
  logic             w_par_bit;
  logic             w_par_nxt;

  // Parity is captured at accept time so the shift register can be consumed freely.
`ifdef PISO_SERIAL_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end

  assign w_par_nxt  = w_accept ? ^load_data : r_par;
  assign w_par_bit  = r_par;
  assign w_par_slot = (r_cnt == DataLastCnt);
`else
  assign w_par_nxt  = 1'b0;
  assign w_par_bit  = 1'b0;
  assign w_par_slot = 1'b0;
`endif

  assign w_last     = (r_state == StShift) && (r_cnt == LastCnt);
  // Gated by rst so the upstream never sees ready while the block is held in reset.
  assign load_ready = ~rst & ((r_state == StIdle) | w_last);
  assign w_accept   = load_valid & load_ready;

  assign dout       = r_dout;
  assign dout_valid = (r_state == StShift);
  assign dout_last  = w_last;
  assign busy       = dout_valid;

  // First bit goes straight to the output flop; the shift register keeps the remainder.
  always_comb begin
    if (MSB_FIRST) begin
      w_first_bit  = load_data[WIDTH-1];
      w_first_rest = {load_data[WIDTH-2:0], 1'b0};
      w_next_bit   = r_shreg[WIDTH-1];
      w_next_rest  = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      w_first_bit  = load_data[0];
      w_first_rest = {1'b0, load_data[WIDTH-1:1]};
      w_next_bit   = r_shreg[0];
      w_next_rest  = {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_dout_nxt  = r_dout;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StShift;
          w_cnt_nxt   = '0;
          w_dout_nxt  = w_first_bit;
          w_shreg_nxt = w_first_rest;
        end
      end
      StShift: begin
        if (w_last) begin
          if (w_accept) begin
            w_cnt_nxt   = '0;
            w_dout_nxt  = w_first_bit;
            w_shreg_nxt = w_first_rest;
          end else begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
            w_dout_nxt  = 1'b0;
            w_shreg_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_par_slot) begin
            w_dout_nxt = w_par_bit;
          end else begin
            w_dout_nxt  = w_next_bit;
            w_shreg_nxt = w_next_rest;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_dout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

endmodule
